multicycle_ctrl: RTL and testbench

//  Multi-cycle control unit sitting directly upstream of the datapath.

---
 rtl/multicycle_ctrl.sv | 119 +++++++++++
 tb/tb_multicycle_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM with registered datapath controls; perf counters under CTRL_PERF_CNT_EN
module multicycle_ctrl #(
  parameter int INS_W    = 32,
  parameter int ALU_CC_W = 4,
  parameter int MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INS_W-1:0]    IM,
  input  logic                stall,
  output logic                PC_en,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic                ALUsrc,
  output logic                MemWrite,
  output logic                MemRead,
  output logic [ALU_CC_W-1:0] ALU_CC,
  output logic                illegal,
  output logic [2:0]          state_o,
  output logic [31:0]         retired,
  output logic [31:0]         cycles
);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state;
  logic [INS_W-1:0] ir;
  logic [CW-1:0] cnt;
  logic is_r, is_i, is_ld, is_st, legal, last_mem, mw_next;
  logic [3:0] cc, alu;
  logic unused_bits;
  assign is_r = ir[6:0] == 7'b0110011;
  assign is_i = ir[6:0] == 7'b0010011;
  assign is_ld = ir[6:0] == 7'b0000011;
  assign is_st = ir[6:0] == 7'b0100011;
  assign legal = is_r || is_i || is_ld || is_st;
  assign last_mem = cnt == CW'(MEM_LAT - 1);
  assign mw_next = is_st && (CW'(cnt + 1'b1) == CW'(MEM_LAT - 1));
  assign alu = (is_r || is_i) ? cc : 4'b0010;
  assign state_o = state;
  assign unused_bits = ^{ir[INS_W-1:31], ir[29:15], ir[11:7]};
  always_comb begin
    cc = 4'b0010;
    case (ir[14:12])
      3'b000: cc = (is_r && ir[30]) ? 4'b0110 : 4'b0010;
      3'b001: cc = 4'b0100;
      3'b010: cc = 4'b0111;
      3'b100: cc = 4'b0011;
      3'b101: cc = ir[30] ? 4'b1000 : 4'b0101;
      3'b110: cc = 4'b0001;
      3'b111: cc = 4'b0000;
      default: cc = 4'b0010;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ir <= '0;
      cnt <= '0;
      {PC_en, RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead, illegal} <= '0;
      ALU_CC <= '0;
    end else begin
      {PC_en, RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead} <= '0;
      ALU_CC <= '0;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (!stall) begin
            ir <= IM;
            state <= DECODE;
          end
        end
        DECODE: begin
          state <= legal ? EXEC : TRAP;
          illegal <= !legal;
          ALUsrc <= legal && !is_r;
          ALU_CC <= legal ? ALU_CC_W'(alu) : '0;
        end
        EXEC: begin
          ALUsrc <= !is_r;
          ALU_CC <= ALU_CC_W'(alu);
          cnt <= '0;
          state <= (is_r || is_i) ? WB : MEM;
          RegWrite <= is_r || is_i;
          PC_en <= is_r || is_i || (is_st && MEM_LAT == 1);
          MemWrite <= is_st && MEM_LAT == 1;
          MemRead <= is_ld;
        end
        MEM: begin
          ALUsrc <= last_mem ? is_ld : 1'b1;
          ALU_CC <= (last_mem && is_st) ? '0 : ALU_CC_W'(alu);
          MemRead <= is_ld;
          cnt <= last_mem ? cnt : CW'(cnt + 1'b1);
          state <= last_mem ? (is_ld ? WB : FETCH) : MEM;
          RegWrite <= last_mem && is_ld;
          MemtoReg <= last_mem && is_ld;
          PC_en <= last_mem ? is_ld : mw_next;
          MemWrite <= !last_mem && mw_next;
        end
        WB: state <= FETCH;
        TRAP: state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
      retired <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      retired <= retired + {31'd0, PC_en};
    end
  end
`else
  assign cycles = '0;
  assign retired = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl with MEM_LAT=1 and MEM_LAT=3 instances
module tb_multicycle_ctrl;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst1 = 1, stall1 = 0, rst3 = 1, stall3 = 0;
  logic [31:0] im1 = 0, im3 = 0;
  logic pc1, rw1, m2r1, as1, mw1, mr1, ill1, pc3, rw3, m2r3, as3, mw3, mr3, ill3;
  logic [3:0] cc1, cc3;
  logic [2:0] st1, st3;
  logic [31:0] ret1, cyc1, ret3, cyc3;
  multicycle_ctrl #(.MEM_LAT(1)) d1 (
    .clk(clk), .reset(rst1), .IM(im1), .stall(stall1), .PC_en(pc1), .RegWrite(rw1),
    .MemtoReg(m2r1), .ALUsrc(as1), .MemWrite(mw1), .MemRead(mr1), .ALU_CC(cc1),
    .illegal(ill1), .state_o(st1), .retired(ret1), .cycles(cyc1)
  );
  multicycle_ctrl #(.MEM_LAT(3)) d3 (
    .clk(clk), .reset(rst3), .IM(im3), .stall(stall3), .PC_en(pc3), .RegWrite(rw3),
    .MemtoReg(m2r3), .ALUsrc(as3), .MemWrite(mw3), .MemRead(mr3), .ALU_CC(cc3),
    .illegal(ill3), .state_o(st3), .retired(ret3), .cycles(cyc3)
  );
  wire [13:0] a1 = {st1, pc1, rw1, m2r1, as1, mw1, mr1, cc1, ill1};
  wire [13:0] a3 = {st3, pc3, rw3, m2r3, as3, mw3, mr3, cc3, ill3};
  typedef struct {
    int d;
    bit cnt;
    logic [13:0] v;
    logic [31:0] ret;
    logic [31:0] cyc;
    string n;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int vectors = 0, miscompares = 0;
  function automatic logic [13:0] v(logic [2:0] st, logic pc, logic rw, logic m2r, logic as,
                                    logic mw, logic mr, logic [3:0] cc, logic ill);
    return {st, pc, rw, m2r, as, mw, mr, cc, ill};
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (e.cnt) begin
        if ((e.d == 1 ? {ret1, cyc1} : {ret3, cyc3}) !== {e.ret, e.cyc}) begin
          miscompares++;
          $display("FAIL %s dut%0d: retired/cycles got %0d/%0d want %0d/%0d", e.n, e.d,
                   e.d == 1 ? ret1 : ret3, e.d == 1 ? cyc1 : cyc3, e.ret, e.cyc);
        end
      end else if ((e.d == 1 ? a1 : a3) !== e.v) begin
        miscompares++;
        $display("FAIL %s dut%0d: {state,pc,rw,m2r,as,mw,mr,cc,ill} got %b want %b", e.n, e.d,
                 e.d == 1 ? a1 : a3, e.v);
      end
    end
  end
  task automatic step(int d, logic r, logic s, logic [31:0] im, string n, logic [13:0] ev);
    exp_t x;
    if (d == 1) begin
      rst1 = r; stall1 = s; im1 = im;
    end else begin
      rst3 = r; stall3 = s; im3 = im;
    end
    @(posedge clk);
    #1;
    x.d = d; x.cnt = 0; x.v = ev; x.ret = 0; x.cyc = 0; x.n = n;
    q.push_back(x);
  endtask
  task automatic chk_cnt(int d, logic [31:0] r, logic [31:0] c, string n);
    exp_t x;
    x.d = d; x.cnt = 1; x.v = 0; x.ret = r; x.cyc = c; x.n = n;
    q.push_back(x);
  endtask
  // kind: 0 R-type, 1 I-ALU, 2 load, 3 store; starts and ends in FETCH
  task automatic instr(int d, logic [31:0] im, int kind, logic [3:0] cc, int lat, string n);
    logic as;
    as = (kind != 0);
    step(d, 0, 0, im, n, v(2, 0, 0, 0, 0, 0, 0, 0, 0));
    step(d, 0, 0, im, n, v(3, 0, 0, 0, as, 0, 0, cc, 0));
    if (kind < 2) step(d, 0, 0, im, n, v(5, 1, 1, 0, as, 0, 0, cc, 0));
    else begin
      for (int k = 0; k < lat; k++)
        step(d, 0, 0, im, n, v(4, kind == 3 && k == lat - 1, 0, 0, as,
                              kind == 3 && k == lat - 1, kind == 2, cc, 0));
      if (kind == 2) step(d, 0, 0, im, n, v(5, 1, 1, 1, as, 0, 1, cc, 0));
    end
    step(d, 0, 0, im, n, v(1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  initial begin
    step(1, 1, 0, 0, "reset", v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk_cnt(1, 0, 0, "reset_cnt");
    step(1, 0, 0, 0, "idle_to_fetch", v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    instr(1, 32'h002081B3, 0, 4'b0010, 1, "add");
    instr(1, 32'h402081B3, 0, 4'b0110, 1, "sub");
    instr(1, 32'h00500093, 1, 4'b0010, 1, "addi");
    instr(1, 32'h0020C1B3, 0, 4'b0011, 1, "xor");
    instr(1, 32'h0020D1B3, 0, 4'b0101, 1, "srl");
    instr(1, 32'h4020D1B3, 0, 4'b1000, 1, "sra");
    instr(1, 32'h0020F1B3, 0, 4'b0000, 1, "and");
    instr(1, 32'h0020E1B3, 0, 4'b0001, 1, "or");
    instr(1, 32'h0020A1B3, 0, 4'b0111, 1, "slt");
    instr(1, 32'h00209193, 1, 4'b0100, 1, "slli");
    instr(1, 32'h0020B1B3, 0, 4'b0010, 1, "sltu_unsup");
    instr(1, 32'h00502623, 3, 4'b0010, 1, "sw_lat1");
    instr(1, 32'h00802283, 2, 4'b0010, 1, "lw_lat1");
    for (int i = 0; i < 5; i++) step(1, 0, 1, 32'hFFFFFFFF, "stall", v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    instr(1, 32'h002081B3, 0, 4'b0010, 1, "add_after_stall");
    step(1, 0, 0, 32'hFFFFFFFF, "trap_decode", v(2, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h002081B3, "trap_hold", v(6, 0, 0, 0, 0, 0, 0, 0, 1));
    step(1, 1, 0, 0, "trap_reset", v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0, 0, "trap_refetch", v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 0, 0, "perf_reset", v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 0, 0, 0, "perf_fetch", v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) instr(1, 32'h002081B3, 0, 4'b0010, 1, "perf_add");
`ifdef CTRL_PERF_CNT_EN
    chk_cnt(1, 10, 41, "perf_counts");
`else
    chk_cnt(1, 0, 0, "perf_counts_off");
`endif
    step(3, 1, 0, 0, "reset3", v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(3, 0, 0, 0, "fetch3", v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    instr(3, 32'h00802283, 2, 4'b0010, 3, "lw_lat3");
    instr(3, 32'h00502623, 3, 4'b0010, 3, "sw_lat3");
    step(3, 0, 0, 32'h00502623, "abort_decode", v(2, 0, 0, 0, 0, 0, 0, 0, 0));
    step(3, 0, 0, 32'h00502623, "abort_exec", v(3, 0, 0, 0, 1, 0, 0, 4'b0010, 0));
    step(3, 0, 0, 32'h00502623, "abort_mem1", v(4, 0, 0, 0, 1, 0, 0, 4'b0010, 0));
    step(3, 0, 0, 32'h00502623, "abort_mem2", v(4, 0, 0, 0, 1, 0, 0, 4'b0010, 0));
    step(3, 1, 0, 32'h00502623, "abort_reset", v(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(3, 0, 0, 0, "abort_refetch", v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    instr(3, 32'h00500093, 1, 4'b0010, 3, "addi_lat3");
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
